falu_result_wb: RTL and testbench

//  Writeback stage directly downstream of floating_ALU_TOP. Accepts one issue per

---
 rtl/falu_result_wb.sv | 201 ++++++++++++++++++++
 tb/tb_falu_result_wb.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/falu_result_wb.sv
// falu_result_wb: writeback stage after the floating-point ALU.
// Picks the result bus named by ALU_FUNC and holds it in a two-entry
// skid buffer (head + skid) toward the register-file write port.
// Optional feature macro: FALU_WB_FLAGS_EN adds sticky RISC-V fflags
// accumulation; without it FFLAGS is tied to zero.
module falu_result_wb #(
    parameter int OP_DATA_WIDTH = 32
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         IN_VALID,
    output logic                         IN_READY,
    input  logic [4:0]                   ALU_FUNC,
    input  logic [4:0]                   RD_ADDR,
    input  logic [OP_DATA_WIDTH-1:0]     A,
    input  logic [OP_DATA_WIDTH-1:0]     B,
    input  logic [OP_DATA_WIDTH-1:0]     OUT_FMADD,
    input  logic [OP_DATA_WIDTH-1:0]     OUT_FNMADD,
    input  logic [OP_DATA_WIDTH-1:0]     OUT_FMSUB,
    input  logic [OP_DATA_WIDTH-1:0]     OUT_FNMSUB,
    input  logic [OP_DATA_WIDTH-1:0]     OUT_ADD,
    input  logic [OP_DATA_WIDTH-1:0]     OUT_SUB,
    input  logic [OP_DATA_WIDTH-1:0]     OUT_MUL,
    input  logic [OP_DATA_WIDTH-1:0]     OUT_DIV,
    input  logic [OP_DATA_WIDTH-1:0]     OUT_FSQRT,
    input  logic [OP_DATA_WIDTH-1:0]     OUT_FSGNJ,
    input  logic [OP_DATA_WIDTH-1:0]     OUT_FSGNJN,
    input  logic [OP_DATA_WIDTH-1:0]     OUT_FSGNJX,
    input  logic [OP_DATA_WIDTH-1:0]     OUT_MIN_MAX,
    input  logic [9:0]                   OUT_CLASS,
    input  logic [2*OP_DATA_WIDTH-1:0]   OUT_FMV_X_W,
    input  logic [OP_DATA_WIDTH-1:0]     OUT_FMV_W_X,
    output logic                         OUT_VALID,
    input  logic                         OUT_READY,
    output logic [2*OP_DATA_WIDTH-1:0]   OUT_DATA,
    output logic [4:0]                   OUT_RD,
    output logic                         OUT_ILLEGAL,
    output logic [4:0]                   FFLAGS,
    input  logic                         FFLAGS_CLR
);
    localparam int W  = OP_DATA_WIDTH;
    localparam int DW = 2 * OP_DATA_WIDTH;

    logic [DW-1:0] w_sel_data;
    logic          w_sel_ill;
    logic          w_push;
    logic          w_pop;
    logic          w_head_load;
    logic          w_head_from_skid;
    logic          w_skid_load;

    logic          r_head_vld;
    logic [DW-1:0] r_head_data;
    logic [4:0]    r_head_rd;
    logic          r_head_ill;
    logic          r_skid_vld;
    logic [DW-1:0] r_skid_data;
    logic [4:0]    r_skid_rd;
    logic          r_skid_ill;

    // Result mux: W-bit buses and CLASS are zero-extended, FMV_X_W is full width.
    always_comb begin
        w_sel_data = '0;
        w_sel_ill  = 1'b0;
        case (ALU_FUNC)
            5'd0:    w_sel_data = {{W{1'b0}}, OUT_FMADD};
            5'd1:    w_sel_data = {{W{1'b0}}, OUT_FNMADD};
            5'd2:    w_sel_data = {{W{1'b0}}, OUT_FMSUB};
            5'd3:    w_sel_data = {{W{1'b0}}, OUT_FNMSUB};
            5'd4:    w_sel_data = {{W{1'b0}}, OUT_ADD};
            5'd5:    w_sel_data = {{W{1'b0}}, OUT_SUB};
            5'd6:    w_sel_data = {{W{1'b0}}, OUT_MUL};
            5'd7:    w_sel_data = {{W{1'b0}}, OUT_DIV};
            5'd8:    w_sel_data = {{W{1'b0}}, OUT_FSQRT};
            5'd9:    w_sel_data = {{W{1'b0}}, OUT_FSGNJ};
            5'd10:   w_sel_data = {{W{1'b0}}, OUT_FSGNJN};
            5'd11:   w_sel_data = {{W{1'b0}}, OUT_FSGNJX};
            5'd12:   w_sel_data = {{W{1'b0}}, OUT_MIN_MAX};
            5'd13:   w_sel_data = {{(DW-10){1'b0}}, OUT_CLASS};
            5'd14:   w_sel_data = OUT_FMV_X_W;
            5'd15:   w_sel_data = {{W{1'b0}}, OUT_FMV_W_X};
            default: w_sel_ill  = 1'b1;
        endcase
    end

    // IN_READY comes straight from a register: room exists while the skid is empty.
    assign IN_READY         = ~r_skid_vld;
    assign w_push           = IN_VALID & ~r_skid_vld;
    assign w_pop            = r_head_vld & OUT_READY;
    // A push can only coincide with a valid skid never, so these loads are exclusive.
    assign w_head_from_skid = w_pop & r_skid_vld;
    assign w_head_load      = w_push & (~r_head_vld | w_pop);
    assign w_skid_load      = w_push & r_head_vld & ~w_pop;

    assign OUT_VALID   = r_head_vld;
    assign OUT_DATA    = r_head_data;
    assign OUT_RD      = r_head_rd;
    assign OUT_ILLEGAL = r_head_ill;

    // Head/skid storage; head keeps its last contents after a pop that empties it.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_head_vld  <= 1'b0;
            r_head_data <= '0;
            r_head_rd   <= '0;
            r_head_ill  <= 1'b0;
            r_skid_vld  <= 1'b0;
            r_skid_data <= '0;
            r_skid_rd   <= '0;
            r_skid_ill  <= 1'b0;
        end else begin
            r_head_vld <= w_head_load | w_head_from_skid | (r_head_vld & ~w_pop);
            r_skid_vld <= w_skid_load | (r_skid_vld & ~w_pop);
            if (w_head_from_skid) begin
                r_head_data <= r_skid_data;
                r_head_rd   <= r_skid_rd;
                r_head_ill  <= r_skid_ill;
            end else if (w_head_load) begin
                r_head_data <= w_sel_data;
                r_head_rd   <= RD_ADDR;
                r_head_ill  <= w_sel_ill;
            end
            if (w_skid_load) begin
                r_skid_data <= w_sel_data;
                r_skid_rd   <= RD_ADDR;
                r_skid_ill  <= w_sel_ill;
            end
        end
    end

`ifdef FALU_WB_FLAGS_EN
    logic [W-1:0] w_res;
    logic         w_arith;
    logic [4:0]   w_new_flags;
    logic [4:0]   r_head_flg;
    logic [4:0]   r_skid_flg;
    logic [4:0]   r_fflags;

    function automatic logic f_exp_ones(input logic [W-1:0] v);
        return &v[W-2:W-9];
    endfunction

    function automatic logic f_man_zero(input logic [W-1:0] v);
        return ~|v[W-10:0];
    endfunction

    function automatic logic f_is_nan(input logic [W-1:0] v);
        return f_exp_ones(v) & ~f_man_zero(v);
    endfunction

    function automatic logic f_is_inf(input logic [W-1:0] v);
        return f_exp_ones(v) & f_man_zero(v);
    endfunction

    function automatic logic f_is_sub(input logic [W-1:0] v);
        return ~|v[W-2:W-9] & ~f_man_zero(v);
    endfunction

    function automatic logic f_is_zero(input logic [W-1:0] v);
        return ~|v[W-2:0];
    endfunction

    assign w_res   = w_sel_data[W-1:0];
    assign w_arith = (ALU_FUNC <= 5'd7);

    // {NV,DZ,OF,UF,NX}; inexact is never reported by this stage.
    assign w_new_flags[4] = w_sel_ill | ((ALU_FUNC <= 5'd8) & f_is_nan(w_res) &
                                         ~f_is_nan(A) & ~f_is_nan(B));
    assign w_new_flags[3] = (ALU_FUNC == 5'd7) & f_is_zero(B) & ~f_exp_ones(A) & ~f_is_zero(A);
    assign w_new_flags[2] = w_arith & f_is_inf(w_res) & ~f_exp_ones(A) & ~f_exp_ones(B);
    assign w_new_flags[1] = w_arith & f_is_sub(w_res);
    assign w_new_flags[0] = 1'b0;

    assign FFLAGS = r_fflags;

    // Per-entry flags follow their entry; sticky flags absorb them on pop (pop beats clear).
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_head_flg <= '0;
            r_skid_flg <= '0;
            r_fflags   <= '0;
        end else begin
            if (w_head_from_skid)
                r_head_flg <= r_skid_flg;
            else if (w_head_load)
                r_head_flg <= w_new_flags;
            if (w_skid_load)
                r_skid_flg <= w_new_flags;
            if (w_pop)
                r_fflags <= (FFLAGS_CLR ? 5'b0 : r_fflags) | r_head_flg;
            else if (FFLAGS_CLR)
                r_fflags <= 5'b0;
        end
    end
`else
    logic w_unused;
    assign w_unused = ^{A, B, FFLAGS_CLR};
    assign FFLAGS   = 5'b0;
`endif

endmodule

// File: tb/tb_falu_result_wb.sv
// Self-checking bench for falu_result_wb: scoreboard queue filled at issue,
// drained and compared at each writeback handshake.
module tb_falu_result_wb;
    localparam int W = 32;

    logic          CLK = 1'b0;
    logic          RST;
    logic          IN_VALID;
    logic          IN_READY;
    logic [4:0]    ALU_FUNC;
    logic [4:0]    RD_ADDR;
    logic [W-1:0]  A, B;
    logic [W-1:0]  bus [16];
    logic [63:0]   fmvxw;
    logic          OUT_VALID;
    logic          OUT_READY;
    logic [63:0]   OUT_DATA;
    logic [4:0]    OUT_RD;
    logic          OUT_ILLEGAL;
    logic [4:0]    FFLAGS;
    logic          FFLAGS_CLR;

    typedef struct packed {
        logic [63:0] data;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [4:0] exp_flags;

    always #5 CLK = ~CLK;

    falu_result_wb #(.OP_DATA_WIDTH(W)) dut (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .ALU_FUNC(ALU_FUNC), .RD_ADDR(RD_ADDR), .A(A), .B(B),
        .OUT_FMADD(bus[0]), .OUT_FNMADD(bus[1]), .OUT_FMSUB(bus[2]), .OUT_FNMSUB(bus[3]),
        .OUT_ADD(bus[4]), .OUT_SUB(bus[5]), .OUT_MUL(bus[6]), .OUT_DIV(bus[7]),
        .OUT_FSQRT(bus[8]), .OUT_FSGNJ(bus[9]), .OUT_FSGNJN(bus[10]), .OUT_FSGNJX(bus[11]),
        .OUT_MIN_MAX(bus[12]), .OUT_CLASS(bus[13][9:0]), .OUT_FMV_X_W(fmvxw),
        .OUT_FMV_W_X(bus[15]), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .OUT_DATA(OUT_DATA), .OUT_RD(OUT_RD), .OUT_ILLEGAL(OUT_ILLEGAL),
        .FFLAGS(FFLAGS), .FFLAGS_CLR(FFLAGS_CLR)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] model(input logic [4:0] f);
        if (f[4])       return 64'd0;
        if (f == 5'd13) return {54'd0, bus[13][9:0]};
        if (f == 5'd14) return fmvxw;
        return {32'd0, bus[f[3:0]]};
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Present one issue, wait (bounded) for acceptance, record the expectation.
    task automatic issue(input logic [4:0] f, input logic [4:0] rd,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        int k;
        ALU_FUNC = f;
        RD_ADDR  = rd;
        A        = a;
        B        = b;
        IN_VALID = 1'b1;
        k = 0;
        while (!IN_READY && k < 40) begin
            if (k == 3) OUT_READY = 1'b1;
            step();
            k++;
        end
        if (!IN_READY) begin
            chk("in_ready_timeout", {63'd0, IN_READY}, 64'd1);
        end else begin
            sb.push_back('{data: model(f), rd: rd, ill: f[4]});
            step();
        end
        IN_VALID = 1'b0;
    endtask

    task automatic drain();
        int k;
        OUT_READY = 1'b1;
        k = 0;
        while ((sb.size() != 0 || OUT_VALID) && k < 40) begin
            step();
            k++;
        end
        chk("drain_left", 64'(sb.size()), 64'd0);
    endtask

    // Writeback monitor: every handshake pops the oldest expectation.
    always @(negedge CLK) begin
        if (RST && OUT_VALID && OUT_READY) begin
            if (sb.size() == 0) begin
                chk("spurious_pop", 64'd1, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("wb_data", OUT_DATA, mon_e.data);
                chk("wb_rd", {59'd0, OUT_RD}, {59'd0, mon_e.rd});
                chk("wb_ill", {63'd0, OUT_ILLEGAL}, {63'd0, mon_e.ill});
            end
        end
    end

    initial begin
        RST = 1'b0; IN_VALID = 1'b0; ALU_FUNC = '0; RD_ADDR = '0; A = '0; B = '0;
        OUT_READY = 1'b1; FFLAGS_CLR = 1'b0; fmvxw = 64'h1122_3344_5566_7788;
        for (int i = 0; i < 16; i++) bus[i] = 32'h3F80_0000 + 32'(i * 32'h0101_0011);
        step(); step();
        chk("rst_out_valid", {63'd0, OUT_VALID}, 64'd0);
        chk("rst_in_ready", {63'd0, IN_READY}, 64'd1);
        chk("rst_out_data", OUT_DATA, 64'd0);
        chk("rst_out_rd", {59'd0, OUT_RD}, 64'd0);
        chk("rst_out_ill", {63'd0, OUT_ILLEGAL}, 64'd0);
        chk("rst_fflags", {59'd0, FFLAGS}, 64'd0);
        RST = 1'b1;
        step();

        // DIV, one-cycle latency
        bus[7] = 32'h40A0_0000;
        issue(5'd7, 5'd5, 32'h41C8_0000, 32'h40A0_0000);
        chk("div_latency_valid", {63'd0, OUT_VALID}, 64'd1);
        chk("div_rd", {59'd0, OUT_RD}, 64'd5);
        chk("div_data", OUT_DATA, 64'h0000_0000_40A0_0000);
        drain();

        // Backpressure: two fill the buffer, third waits for release
        OUT_READY = 1'b0;
        issue(5'd4, 5'd1, 32'h3F80_0000, 32'h3F80_0000);
        issue(5'd5, 5'd2, 32'h3F80_0000, 32'h3F80_0000);
        chk("full_in_ready", {63'd0, IN_READY}, 64'd0);
        step(); step();
        chk("hold_valid", {63'd0, OUT_VALID}, 64'd1);
        chk("hold_rd", {59'd0, OUT_RD}, 64'd1);
        chk("hold_data", OUT_DATA, {32'd0, bus[4]});
        OUT_READY = 1'b1;
        issue(5'd6, 5'd3, 32'h3F80_0000, 32'h3F80_0000);
        drain();
        chk("empty_hold_rd", {59'd0, OUT_RD}, 64'd3);
        chk("empty_valid", {63'd0, OUT_VALID}, 64'd0);

        // Illegal code
        issue(5'b10010, 5'd9, 32'h0, 32'h0);
        drain();
`ifdef FALU_WB_FLAGS_EN
        exp_flags = 5'b10000;
`else
        exp_flags = 5'b00000;
`endif
        chk("illegal_fflags", {59'd0, FFLAGS}, {59'd0, exp_flags});

        // Divide by zero, then clear coinciding with a second DZ pop
        FFLAGS_CLR = 1'b1;
        step();
        FFLAGS_CLR = 1'b0;
        chk("fflags_cleared", {59'd0, FFLAGS}, 64'd0);
`ifdef FALU_WB_FLAGS_EN
        exp_flags = 5'b01000;
`else
        exp_flags = 5'b00000;
`endif
        bus[7] = 32'h40A0_0000;
        issue(5'd7, 5'd10, 32'h41C8_0000, 32'h0);
        drain();
        chk("dz_fflags", {59'd0, FFLAGS}, {59'd0, exp_flags});
        issue(5'd7, 5'd11, 32'h41C8_0000, 32'h0);
        FFLAGS_CLR = 1'b1;
        step();
        FFLAGS_CLR = 1'b0;
        chk("dz_clr_pop_fflags", {59'd0, FFLAGS}, {59'd0, exp_flags});
        drain();

        // Full-width move and class
        fmvxw = 64'hC0CC_CCCC_CC41_6960;
        issue(5'd14, 5'd12, 32'h0, 32'h0);
        bus[13] = 32'hFFFF_F040;
        issue(5'd13, 5'd13, 32'h0, 32'h0);
        drain();

        // Mixed stream with random backpressure
        for (int i = 0; i < 24; i++) begin
            logic [4:0] f;
            f = 5'($urandom_range(0, 17));
            if (f < 5'd16) bus[f[3:0]] = $urandom;
            fmvxw = {$urandom, $urandom};
            OUT_READY = 1'($urandom_range(0, 1));
            issue(f, 5'(i), $urandom, $urandom);
        end
        drain();

        // Reset while two entries are held
        OUT_READY = 1'b0;
        issue(5'd4, 5'd20, 32'h0, 32'h0);
        issue(5'd5, 5'd21, 32'h0, 32'h0);
        #1 RST = 1'b0;
        #1;
        chk("midrst_out_valid", {63'd0, OUT_VALID}, 64'd0);
        chk("midrst_in_ready", {63'd0, IN_READY}, 64'd1);
        chk("midrst_fflags", {59'd0, FFLAGS}, 64'd0);
        chk("midrst_out_data", OUT_DATA, 64'd0);
        sb.delete();
        step();
        RST = 1'b1;
        step();
        OUT_READY = 1'b1;
        issue(5'd9, 5'd22, 32'h0, 32'h0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
